alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
- Time-shares one combinational ALU instance between two requesters: port 0 is the pipeline EX stage, port 1 is an auxiliary/debug engine.
- Each requester uses a valid/ready request channel. Results come back through a single registered response channel tagged with the requester ID.
- Arbitration is round-robin. Results appear one cycle after acceptance.
- Sits between the requesters and the ALU; owns the ALUOp encoding check.

Parameters:
- W, 32, operand/result width (ALU fixed at 32; other values unsupported).
- NREQ, 2, number of requesters (fixed 2 in this revision).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester accept; request i transfers when req_valid[i] & req_ready[i].
- req_op0, req_op1  in  4 each  ALUOp per requester (0..14 legal).
- req_a0, req_a1  in  32 each  operand A.
- req_b0, req_b1  in  32 each  operand B.
- req_s0, req_s1  in  5 each  shift amount.
- resp_valid  out  1  result register holds a result.
- resp_ready  in  1  consumer accepts the result this cycle.
- resp_id  out  1  requester that issued the result.
- resp_data  out  32  ALU result.
- resp_err  out  1  op was 15 (illegal); resp_data forced to 0.

Behaviour:
- Reset (async, reset_n=0): resp_valid=0, resp_id=0, resp_data=0, resp_err=0, priority pointer=0; req_ready=0 while reset_n=0.
- State is the result register only.
  - EMPTY (resp_valid=0) -> FULL on a grant.
  - FULL -> EMPTY on resp_ready with no new grant.
  - FULL -> FULL on resp_ready plus a new grant (back-to-back, no bubble).
- can_issue = !resp_valid | resp_ready.
- Grant, combinational, one per cycle:
  - Only one valid -> that one.
  - Both valid -> requester at the priority pointer.
  - req_ready[i] = can_issue & grant[i]. Never both bits high.
  - req_ready depends on req_valid; requesters must not wait for req_ready before asserting req_valid.
- Pointer update: after each accepted transfer the pointer = ~granted id. Pointer holds when nothing is accepted.
- Grant mux drives the ALU inputs (op, A, B, s) from the granted requester.
- On transfer, register: resp_data=ALU C, resp_id=granted id, resp_err=(op==15), resp_valid=1.
- Latency: accept in cycle N -> resp_valid in cycle N+1.
- Throughput: 1 op/cycle while resp_ready=1.
- Back-pressure: resp_valid=1 & resp_ready=0 -> req_ready=00. resp_data, resp_id and resp_err are held stable until consumed.
- Fairness: with both requesters continuously valid and resp_ready=1, grants alternate 0,1,0,1...
- A requester may drop req_valid without a transfer; no state is affected.
- Width rules:
  - All ops are 32-bit wrap-around.
  - Op 13 is a signed compare, op 14 an unsigned compare; result is 0 or 1.
  - Ops 8/10/12 use A[4:0] as the shift amount. Ops 7/9/11 use s.
- Reset mid-operation: an in-flight result is discarded and resp_valid drops immediately (async).

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_grant0 and stat_grant1 (16 bits each). Each counts accepted transfers per requester and saturates at 0xFFFF.
  - Adds output stat_stall (16 bits, saturating). It counts cycles with any req_valid high and req_ready=00.
  - All counters reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - ALUOp constants: ADD=0, SUB=1, OR=2, PASSB=3, AND=4, XOR=5, NOR=6, SLL=7, SLLV=8, SRA=9, SRAV=10, SRL=11, SRLV=12, SLT=13, SLTU=14, ILLEGAL=15.
  - W=32.
- One sub-module: rr_arb2, a 2-way round-robin grant generator with pointer register.
- The existing ALU module is instantiated unchanged.

Test Plan:
- Single op: reset released; req0 op=0, A=5, B=7 -> req_ready=01 in same cycle; next cycle resp_valid=1, id=0, data=12, err=0.
- Contention: both valid continuously, resp_ready=1.
  - req0 op=1, A=10, B=3; req1 op=13, A=-1, B=1.
  - Expect responses id 0,1,0,1 with data 7,1,7,1.
  - Expect stat_grant0 = stat_grant1 after 8 cycles (with ALU_ARB_STATS_EN).
- Back-pressure: resp_ready=0 after the first result -> req_ready=00; data held for 5 cycles; resp_ready=1 -> the next grant happens in the same cycle as the drain, with no bubble.
- Shifts/compares:
  - op=10, A=4, B=0x80000000 -> 0xF8000000.
  - op=9, s=31, B=0x80000000 -> 0xFFFFFFFF.
  - op=14, A=0xFFFFFFFF, B=1 -> 0.
- Illegal op: op=15 -> resp_err=1, data=0; the following legal op returns err=0.
- Async reset with resp_valid=1 mid-cycle -> resp_valid=0 without a clock edge; pointer=0; the first grant after release goes to req0 when both are valid.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, requester count, ALUOp encoding
// and a helper that flags the one unused opcode.
package alu_pkg;

   localparam int W    = 32;
   localparam int NREQ = 2;

   typedef enum logic [3:0] {
      OP_ADD     = 4'd0,
      OP_SUB     = 4'd1,
      OP_OR      = 4'd2,
      OP_PASSB   = 4'd3,
      OP_AND     = 4'd4,
      OP_XOR     = 4'd5,
      OP_NOR     = 4'd6,
      OP_SLL     = 4'd7,
      OP_SLLV    = 4'd8,
      OP_SRA     = 4'd9,
      OP_SRAV    = 4'd10,
      OP_SRL     = 4'd11,
      OP_SRLV    = 4'd12,
      OP_SLT     = 4'd13,
      OP_SLTU    = 4'd14,
      OP_ILLEGAL = 4'd15
   } alu_op_e;

   function automatic logic op_is_illegal(input logic [3:0] op);
      return op == OP_ILLEGAL;
   endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Request/response bundle of alu_share_arb.
//   master : requesters + result consumer (drive valid/op/a/b/s, resp_ready)
//   slave  : the arbiter (drives req_ready and the registered response)
// With ALU_ARB_STATS_EN defined the bundle also carries the three
// saturating statistics counters.
interface alu_share_arb_if;
   import alu_pkg::*;

   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [3:0]   req_op0, req_op1;
   logic [W-1:0] req_a0, req_a1;
   logic [W-1:0] req_b0, req_b1;
   logic [4:0]   req_s0, req_s1;
   logic         resp_valid;
   logic         resp_ready;
   logic         resp_id;
   logic [W-1:0] resp_data;
   logic         resp_err;
`ifdef ALU_ARB_STATS_EN
   logic [15:0]  stat_grant0, stat_grant1, stat_stall;
`endif

   modport master (
      output req_valid, req_op0, req_op1, req_a0, req_a1,
             req_b0, req_b1, req_s0, req_s1, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_data, resp_err
`ifdef ALU_ARB_STATS_EN
      , input stat_grant0, stat_grant1, stat_stall
`endif
   );

   modport slave (
      input  req_valid, req_op0, req_op1, req_a0, req_a1,
             req_b0, req_b1, req_s0, req_s1, resp_ready,
      output req_ready, resp_valid, resp_id, resp_data, resp_err
`ifdef ALU_ARB_STATS_EN
      , output stat_grant0, stat_grant1, stat_stall
`endif
   );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU.
//   op : ALUOp, a/b : operands, s : shift amount for SLL/SRA/SRL
//   c  : result; variable shifts take the amount from a[4:0],
//        compares return 0/1, unused opcode returns 0.
module alu
   import alu_pkg::*;
(
   input  logic [3:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [4:0]   s,
   output logic [W-1:0] c
);

   always_comb begin
      c = '0;
      case (op)
         OP_ADD:   c = a + b;
         OP_SUB:   c = a - b;
         OP_OR:    c = a | b;
         OP_PASSB: c = b;
         OP_AND:   c = a & b;
         OP_XOR:   c = a ^ b;
         OP_NOR:   c = ~(a | b);
         OP_SLL:   c = b << s;
         OP_SLLV:  c = b << a[4:0];
         OP_SRA:   c = $unsigned($signed(b) >>> s);
         OP_SRAV:  c = $unsigned($signed(b) >>> a[4:0]);
         OP_SRL:   c = b >> s;
         OP_SRLV:  c = b >> a[4:0];
         OP_SLT:   c = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU:  c = {{(W-1){1'b0}}, (a < b)};
         default:  c = '0;
      endcase
   end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant generator.
//   clk, reset_n : clock, async active-low reset (pointer -> requester 0)
//   valid[1:0]   : request lines
//   accept       : a granted request actually transferred this cycle
//   grant[1:0]   : one-hot (or zero) combinational grant
//   gid          : index of the granted requester
module rr_arb2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic [1:0] grant,
   output logic       gid
);

   logic ptr_reg;

   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr_reg ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   assign gid = grant[1];

   // Pointer moves to the other requester only when a transfer happens,
   // so a requester that withdraws its request does not lose its turn.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ptr_reg <= 1'b0;
      else if (accept)
         ptr_reg <= ~gid;
   end

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one ALU between requester 0 (EX stage) and requester 1
// (aux/debug). Round-robin grant, one-deep registered result tagged with
// the requester id, full throughput when the consumer is ready.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : per-requester valid/ready + operands, response channel
// Optional: define ALU_ARB_STATS_EN for stat_grant0/1 and stat_stall
// saturating counters.
module alu_share_arb
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            reset_n,
   alu_share_arb_if.slave  bus
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]   state_reg;
   logic [W-1:0] data_reg;
   logic         id_reg;
   logic         err_reg;

   logic         can_issue;
   logic         xfer;
   logic         gid;
   logic [1:0]   grant;
   logic [3:0]   alu_op;
   logic [W-1:0] alu_a, alu_b, alu_c;
   logic [4:0]   alu_s;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .valid   (bus.req_valid),
      .accept  (xfer),
      .grant   (grant),
      .gid     (gid)
   );

   // A new result can be accepted when the register is empty or is being
   // drained this cycle. reset_n gates ready so nothing is accepted in reset.
   assign can_issue     = (state_reg == ST_EMPTY) | bus.resp_ready;
   assign bus.req_ready = {2{can_issue & reset_n}} & grant;
   assign xfer          = |bus.req_ready;

   assign alu_op = gid ? bus.req_op1 : bus.req_op0;
   assign alu_a  = gid ? bus.req_a1  : bus.req_a0;
   assign alu_b  = gid ? bus.req_b1  : bus.req_b0;
   assign alu_s  = gid ? bus.req_s1  : bus.req_s0;

   alu u_alu (
      .op (alu_op),
      .a  (alu_a),
      .b  (alu_b),
      .s  (alu_s),
      .c  (alu_c)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_EMPTY;
         data_reg  <= '0;
         id_reg    <= 1'b0;
         err_reg   <= 1'b0;
      end else if (xfer) begin
         state_reg <= ST_FULL;
         data_reg  <= op_is_illegal(alu_op) ? '0 : alu_c;
         id_reg    <= gid;
         err_reg   <= op_is_illegal(alu_op);
      end else if (bus.resp_ready) begin
         // Drained with no replacement; payload kept as-is, only valid drops.
         state_reg <= ST_EMPTY;
      end
   end

   assign bus.resp_valid = (state_reg == ST_FULL);
   assign bus.resp_id    = id_reg;
   assign bus.resp_data  = data_reg;
   assign bus.resp_err   = err_reg;

`ifdef ALU_ARB_STATS_EN
   logic [15:0] grant_cnt_reg [2];
   logic [15:0] stall_cnt_reg;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_grant_cnt
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               grant_cnt_reg[gi] <= '0;
            else if (bus.req_ready[gi] && grant_cnt_reg[gi] != 16'hFFFF)
               grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 16'd1;
         end
      end
   endgenerate

   // Stall: someone is asking but nobody is accepted this cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         stall_cnt_reg <= '0;
      else if ((|bus.req_valid) && !xfer && stall_cnt_reg != 16'hFFFF)
         stall_cnt_reg <= stall_cnt_reg + 16'd1;
   end

   assign bus.stat_grant0 = grant_cnt_reg[0];
   assign bus.stat_grant1 = grant_cnt_reg[1];
   assign bus.stat_stall  = stall_cnt_reg;
`endif

endmodule
